// File: rtl/set_gen_pkg.sv
// Shared types and constants for the grid-point set counter.
package set_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [2:0] MODE_A    = 3'd0;  // in[0]
  localparam logic [2:0] MODE_AND  = 3'd1;  // in[0] & in[1]
  localparam logic [2:0] MODE_XOR  = 3'd2;  // in[0] ^ in[1]
  localparam logic [2:0] MODE_TWO  = 3'd3;  // exactly two circles
  localparam logic [2:0] MODE_ANY  = 3'd4;  // union
  localparam logic [2:0] MODE_ALL  = 3'd5;  // intersection of all
  localparam logic [2:0] MODE_ODD  = 3'd6;  // odd membership count
  localparam logic [2:0] MODE_RSVD = 3'd7;  // never hits

  localparam int PIPE_DEPTH = 2;

  // Up to eight membership bits; callers zero-extend narrower vectors.
  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/set_circle_test.sv
// One circle's membership test: registers exact squared distance and squared
// radius, then compares them with an inclusive boundary.
module set_circle_test #(
  parameter int COORD_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [COORD_W-1:0] r,
  output logic               in_circle
);

  localparam int D_W = 2*COORD_W + 3;

  logic signed [COORD_W:0]     dx, dy;
  logic signed [D_W-1:0]       dx_e, dy_e, sum_s;
  logic        [2*COORD_W-1:0] r_e;
  logic        [D_W-1:0]       dist2_q;
  logic        [2*COORD_W-1:0] r2_q;

  // One extra bit keeps the difference exact for centers outside the grid.
  assign dx    = $signed({1'b0, x}) - $signed({1'b0, cx});
  assign dy    = $signed({1'b0, y}) - $signed({1'b0, cy});
  assign dx_e  = {{(D_W-COORD_W-1){dx[COORD_W]}}, dx};
  assign dy_e  = {{(D_W-COORD_W-1){dy[COORD_W]}}, dy};
  assign sum_s = dx_e*dx_e + dy_e*dy_e;
  assign r_e   = {{COORD_W{1'b0}}, r};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dist2_q <= '0;
      r2_q    <= '0;
    end else begin
      dist2_q <= $unsigned(sum_s);
      r2_q    <= r_e * r_e;
    end
  end

  assign in_circle = (dist2_q <= {3'b000, r2_q});

endmodule

// File: rtl/set_counter_gen.sv
// Grid-point set counter: scans GRID x GRID points, one per clock, through a
// 2-stage pipeline. Define POINT_STREAM_EN to expose the per-point stream.
module set_counter_gen
  import set_gen_pkg::*;
#(
  parameter  int GRID     = 8,
  parameter  int COORD_W  = 4,
  parameter  int NUM_CIRC = 3,
  localparam int CNT_W    = $clog2(GRID*GRID+1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_CIRC*2*COORD_W-1:0] central,
  input  logic [NUM_CIRC*COORD_W-1:0]   radius,
  input  logic [2:0]                    mode,
  output logic                          busy,
  output logic                          valid,
  output logic [CNT_W-1:0]              candidate
`ifdef POINT_STREAM_EN
  ,
  output logic                          pt_valid,
  output logic [COORD_W-1:0]            pt_x,
  output logic [COORD_W-1:0]            pt_y,
  output logic                          pt_hit
`endif
);

  localparam logic [COORD_W-1:0] FIRST      = COORD_W'(1);
  localparam logic [COORD_W-1:0] LAST       = COORD_W'(GRID);
  localparam int                 DR_W       = $clog2(PIPE_DEPTH);
  localparam logic [DR_W-1:0]    DRAIN_LAST = DR_W'(PIPE_DEPTH-1);

  state_t                        state;
  logic [NUM_CIRC*2*COORD_W-1:0] central_q;
  logic [NUM_CIRC*COORD_W-1:0]   radius_q;
  logic [2:0]                    mode_q;
  logic [COORD_W-1:0]            x_q, y_q;
  logic [DR_W-1:0]               drain_cnt;
  logic                          s1_valid;
  logic [NUM_CIRC-1:0]           in_bits;
  logic [3:0]                    k;
  logic                          mode_hit, hit;
  logic [CNT_W-1:0]              count;

  // NOTE: every register here uses <= so all state updates see the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      central_q <= '0;
      radius_q  <= '0;
      mode_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      candidate <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            central_q <= central;
            radius_q  <= radius;
            mode_q    <= mode;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (en) begin
            central_q <= central;
            radius_q  <= radius;
            mode_q    <= mode;
          end else begin
            state <= SCAN;
            busy  <= 1'b1;
            x_q   <= FIRST;
            y_q   <= FIRST;
          end
        end
        SCAN: begin
          if (x_q == LAST && y_q == LAST) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            x_q       <= '0;
            y_q       <= '0;
          end else if (x_q == LAST) begin
            x_q <= FIRST;
            y_q <= y_q + FIRST;
          end else begin
            x_q <= x_q + FIRST;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            valid     <= 1'b1;
            candidate <= count;
          end else begin
            drain_cnt <= drain_cnt + DR_W'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          valid     <= 1'b0;
          candidate <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Circle 0 sits in the most significant slot of central/radius.
  for (genvar i = 0; i < NUM_CIRC; i++) begin : g_circ
    localparam int J = NUM_CIRC - 1 - i;
    set_circle_test #(.COORD_W(COORD_W)) u_circ (
      .clk       (clk),
      .rst       (rst),
      .x         (x_q),
      .y         (y_q),
      .cx        (central_q[(2*J+1)*COORD_W +: COORD_W]),
      .cy        (central_q[2*J*COORD_W +: COORD_W]),
      .r         (radius_q[J*COORD_W +: COORD_W]),
      .in_circle (in_bits[i])
    );
  end

  // NOTE: mode_hit gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    k        = popcount(8'(in_bits));
    mode_hit = 1'b0;
    case (mode_q)
      MODE_A:    mode_hit = in_bits[0];
      MODE_AND:  mode_hit = in_bits[0] & in_bits[1];
      MODE_XOR:  mode_hit = in_bits[0] ^ in_bits[1];
      MODE_TWO:  mode_hit = (k == 4'd2);
      MODE_ANY:  mode_hit = (k != 4'd0);
      MODE_ALL:  mode_hit = (k == 4'(NUM_CIRC));
      MODE_ODD:  mode_hit = k[0];
      MODE_RSVD: mode_hit = 1'b0;
      default:   mode_hit = 1'b0;
    endcase
    hit = s1_valid & mode_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      count    <= '0;
    end else begin
      s1_valid <= (state == SCAN);
      if (state == DONE) count <= '0;
      else if (hit)      count <= count + CNT_W'(1);
    end
  end

`ifdef POINT_STREAM_EN
  logic [COORD_W-1:0] s1_x, s1_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_x     <= '0;
      s1_y     <= '0;
      pt_valid <= 1'b0;
      pt_x     <= '0;
      pt_y     <= '0;
      pt_hit   <= 1'b0;
    end else begin
      s1_x     <= x_q;
      s1_y     <= y_q;
      pt_valid <= s1_valid;
      pt_x     <= s1_x;
      pt_y     <= s1_y;
      pt_hit   <= hit;
    end
  end
`endif

endmodule

// File: tb/tb_set_counter_gen.sv
// Self-checking bench for set_counter_gen against a point-by-point model.
module tb_set_counter_gen;

  localparam int GRID = 8;
  localparam int CW   = 4;
  localparam int NC   = 3;
  localparam int CNT  = $clog2(GRID*GRID+1);
  localparam int BUSY_EXP = GRID*GRID + 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en  = 1'b0;
  logic [NC*2*CW-1:0]   central = '0;
  logic [NC*CW-1:0]     radius  = '0;
  logic [2:0]           mode    = '0;
  logic                 busy, valid;
  logic [CNT-1:0]       candidate;
`ifdef POINT_STREAM_EN
  logic                 pt_valid, pt_hit;
  logic [CW-1:0]        pt_x, pt_y;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  int cx [NC];
  int cy [NC];
  int rr [NC];
  int md;

  typedef struct {
    bit got;
    int cand;
    int busy_cyc;
    int leak;
    int beats;
    int hits;
    int order_err;
    bit post_bad;
  } res_t;

  set_counter_gen #(.GRID(GRID), .COORD_W(CW), .NUM_CIRC(NC)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .central   (central),
    .radius    (radius),
    .mode      (mode),
    .busy      (busy),
    .valid     (valid),
    .candidate (candidate)
`ifdef POINT_STREAM_EN
    ,
    .pt_valid  (pt_valid),
    .pt_x      (pt_x),
    .pt_y      (pt_y),
    .pt_hit    (pt_hit)
`endif
  );

  always #5 clk = ~clk;

  // Reference: classify every lattice point directly from the set rules.
  function automatic int model_count();
    int n = 0;
    for (int y = 1; y <= GRID; y++) begin
      for (int x = 1; x <= GRID; x++) begin
        int  k = 0;
        bit  inb [NC];
        bit  h;
        for (int i = 0; i < NC; i++) begin
          inb[i] = ((x-cx[i])*(x-cx[i]) + (y-cy[i])*(y-cy[i])) <= rr[i]*rr[i];
          k += int'(inb[i]);
        end
        case (md)
          0: h = inb[0];
          1: h = inb[0] && inb[1];
          2: h = inb[0] != inb[1];
          3: h = (k == 2);
          4: h = (k >= 1);
          5: h = (k == NC);
          6: h = (k % 2) == 1;
          default: h = 0;
        endcase
        n += int'(h);
      end
    end
    return n;
  endfunction

  task automatic apply_params();
    for (int i = 0; i < NC; i++) begin
      int j = NC - 1 - i;
      central[(2*j+1)*CW +: CW] = CW'(cx[i]);
      central[2*j*CW +: CW]     = CW'(cy[i]);
      radius[j*CW +: CW]        = CW'(rr[i]);
    end
    mode = 3'(md);
  endtask

  task automatic random_params();
    for (int i = 0; i < NC; i++) begin
      cx[i] = int'($urandom_range(0, 15));
      cy[i] = int'($urandom_range(0, 15));
      rr[i] = int'($urandom_range(0, 15));
    end
    md = int'($urandom_range(0, 7));
  endtask

  // Called one time unit after a rising edge, with the DUT idle.
  task automatic start_run();
    apply_params();
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic wait_result(input int pulse_at, input int rst_at, output res_t r);
    r = '{default: 0};
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (pulse_at >= 0 && c == pulse_at) begin
        en      = 1'b1;
        central = ~central;
        radius  = ~radius;
        mode    = mode + 3'd1;
      end
      if (pulse_at >= 0 && c == pulse_at + 1) en = 1'b0;
      if (rst_at >= 0 && c == rst_at)     rst = 1'b1;
      if (rst_at >= 0 && c == rst_at + 1) rst = 1'b0;
      if (busy) r.busy_cyc++;
      if (!valid && candidate != '0) r.leak++;
`ifdef POINT_STREAM_EN
      if (pt_valid) begin
        if (pt_x !== CW'(r.beats % GRID + 1) || pt_y !== CW'(r.beats / GRID + 1))
          r.order_err++;
        r.beats++;
        r.hits += int'(pt_hit);
      end
`endif
      if (valid) begin
        r.got  = 1;
        r.cand = int'(candidate);
        break;
      end
    end
    if (r.got) begin
      @(posedge clk); #1;
      r.post_bad = (valid !== 1'b0) || (candidate !== '0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++;
    if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", valid); end
    tests_run++;
    if (candidate !== '0) begin tests_failed++; $display("FAIL reset_cand: got %0d want 0", candidate); end
`ifdef POINT_STREAM_EN
    tests_run++;
    if ({pt_valid, pt_hit, pt_x, pt_y} !== '0) begin
      tests_failed++; $display("FAIL reset_pt: got %b want 0", {pt_valid, pt_hit, pt_x, pt_y});
    end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int   tbl [9][11];
    res_t r;
    tbl = '{'{4,4,2,  15,15,0, 15,15,0, 0, 13},
            '{1,1,15, 15,15,0, 15,15,0, 0, 64},
            '{4,4,2,  4,4,2,   4,4,2,   1, 13},
            '{4,4,2,  4,4,2,   4,4,2,   2, 0},
            '{4,4,2,  4,4,2,   4,4,2,   3, 0},
            '{4,4,2,  4,4,2,   4,4,2,   5, 13},
            '{1,1,0,  8,8,0,   4,5,0,   4, 3},
            '{1,1,0,  8,8,0,   4,5,0,   6, 3},
            '{1,1,0,  8,8,0,   4,5,0,   7, 0}};
    for (int t = 0; t < 9; t++) begin
      for (int i = 0; i < NC; i++) begin
        cx[i] = tbl[t][3*i]; cy[i] = tbl[t][3*i+1]; rr[i] = tbl[t][3*i+2];
      end
      md = tbl[t][9];
      start_run();
      wait_result(-1, -1, r);
      tests_run++;
      if (!r.got || r.cand != tbl[t][10]) begin
        tests_failed++;
        $display("FAIL dir%0d_cand: got %0d (valid seen %0d) want %0d", t, r.cand, r.got, tbl[t][10]);
      end
      tests_run++;
      if (r.busy_cyc != BUSY_EXP) begin
        tests_failed++; $display("FAIL dir%0d_busy: got %0d cycles want %0d", t, r.busy_cyc, BUSY_EXP);
      end
      tests_run++;
      if (r.leak != 0 || r.post_bad) begin
        tests_failed++; $display("FAIL dir%0d_strobe: leak %0d post %0d want 0 0", t, r.leak, r.post_bad);
      end
`ifdef POINT_STREAM_EN
      tests_run++;
      if (r.beats != GRID*GRID || r.order_err != 0 || r.hits != tbl[t][10]) begin
        tests_failed++;
        $display("FAIL dir%0d_stream: beats %0d order_err %0d hits %0d want %0d 0 %0d",
                 t, r.beats, r.order_err, r.hits, GRID*GRID, tbl[t][10]);
      end
`endif
    end
  endtask

  task automatic test_random();
    res_t r;
    int   exp_c;
    for (int t = 0; t < 8; t++) begin
      random_params();
      exp_c = model_count();
      start_run();
      wait_result(-1, -1, r);
      tests_run++;
      if (!r.got || r.cand != exp_c || r.post_bad) begin
        tests_failed++;
        $display("FAIL rand%0d_cand: got %0d (valid seen %0d) want %0d mode %0d", t, r.cand, r.got, exp_c, md);
      end
`ifdef POINT_STREAM_EN
      tests_run++;
      if (r.beats != GRID*GRID || r.hits != exp_c) begin
        tests_failed++; $display("FAIL rand%0d_stream: beats %0d hits %0d want %0d %0d", t, r.beats, r.hits, GRID*GRID, exp_c);
      end
`endif
    end
  endtask

  task automatic test_load_hold();
    res_t r;
    int   exp_c;
    en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      random_params();
      apply_params();
      @(posedge clk); #1;
    end
    en = 1'b0;
    exp_c   = model_count();
    central = ~central;
    radius  = ~radius;
    wait_result(-1, -1, r);
    tests_run++;
    if (!r.got || r.cand != exp_c) begin
      tests_failed++; $display("FAIL load_hold: got %0d (valid seen %0d) want %0d", r.cand, r.got, exp_c);
    end
    tests_run++;
    if (r.busy_cyc != BUSY_EXP) begin
      tests_failed++; $display("FAIL load_hold_busy: got %0d want %0d", r.busy_cyc, BUSY_EXP);
    end
  endtask

  task automatic test_en_mid_scan();
    res_t r;
    int   exp_c;
    random_params();
    md    = 4;
    exp_c = model_count();
    start_run();
    wait_result(20, -1, r);
    tests_run++;
    if (!r.got || r.cand != exp_c || r.busy_cyc != BUSY_EXP) begin
      tests_failed++;
      $display("FAIL en_mid_scan: got %0d busy %0d (valid seen %0d) want %0d busy %0d",
               r.cand, r.busy_cyc, r.got, exp_c, BUSY_EXP);
    end
  endtask

  task automatic test_abort();
    res_t r;
    int   exp_c;
    cx = '{1, 15, 15}; cy = '{1, 15, 15}; rr = '{15, 0, 0}; md = 0;
    start_run();
    wait_result(-1, 30, r);
    tests_run++;
    if (r.got) begin tests_failed++; $display("FAIL abort_no_valid: got valid with %0d want none", r.cand); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_idle: busy %b want 0", busy); end
    random_params();
    exp_c = model_count();
    start_run();
    wait_result(-1, -1, r);
    tests_run++;
    if (!r.got || r.cand != exp_c) begin
      tests_failed++; $display("FAIL abort_next_run: got %0d (valid seen %0d) want %0d", r.cand, r.got, exp_c);
    end
  endtask

  task automatic test_back_to_back();
    res_t r;
    int   exp_c;
    cx = '{1, 15, 15}; cy = '{1, 15, 15}; rr = '{15, 0, 0}; md = 0;
    start_run();
    wait_result(-1, -1, r);
    tests_run++;
    if (!r.got || r.cand != GRID*GRID) begin
      tests_failed++; $display("FAIL b2b_first: got %0d want %0d", r.cand, GRID*GRID);
    end
    // wait_result leaves us in the cycle right after the valid pulse.
    random_params();
    exp_c = model_count();
    start_run();
    wait_result(-1, -1, r);
    tests_run++;
    if (!r.got || r.cand != exp_c || r.busy_cyc != BUSY_EXP) begin
      tests_failed++;
      $display("FAIL b2b_second: got %0d busy %0d (valid seen %0d) want %0d busy %0d",
               r.cand, r.busy_cyc, r.got, exp_c, BUSY_EXP);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_load_hold();
    test_en_mid_scan();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
